// File: rtl/audio_codec_init_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : audio_codec_init_seq
// Desc     : Walks a fixed 8-entry codec register table, handing one write
//            command per entry to an I2C engine, with power-up delay,
//            per-phase timeout and bounded retry.
// Revision : 1.0 - initial release
// ============================================================================
module audio_codec_init_seq #(
    parameter logic [7:0]  SLAVE_ADDR     = 8'h35,
    parameter int unsigned PWRUP_CYCLES   = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic       osc_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bus_free,
    output logic       cmd_en,
    output logic [7:0] slave_addr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] step
);

    localparam logic [2:0]  c_idle      = 3'd0;
    localparam logic [2:0]  c_pwrup     = 3'd1;
    localparam logic [2:0]  c_issue     = 3'd2;
    localparam logic [2:0]  c_wait_acc  = 3'd3;
    localparam logic [2:0]  c_wait_free = 3'd4;
    localparam logic [2:0]  c_done      = 3'd5;
    localparam logic [2:0]  c_error     = 3'd6;

    localparam logic [15:0] c_pwrup_last = 16'(PWRUP_CYCLES - 1);
    localparam logic [15:0] c_tout_last  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  c_max_retry  = 2'(MAX_RETRY);
    localparam logic [15:0] c_cnt_max    = 16'hFFFF;
    localparam logic [2:0]  c_last_step  = 3'd7;

    // Codec init table: {register, data} in issue order.
    function automatic logic [15:0] f_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    f_entry = 16'h1E00;
            3'd1:    f_entry = 16'h0AFF;
            3'd2:    f_entry = 16'h0BFF;
            3'd3:    f_entry = 16'h0500;
            3'd4:    f_entry = 16'h0702;
            3'd5:    f_entry = 16'h0800;
            3'd6:    f_entry = 16'h2250;
            default: f_entry = 16'h25C0;
        endcase
    endfunction

    logic        r_rst_meta;
    logic        r_rst_sync;
    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [1:0]  r_retry;
    logic [2:0]  r_step;
    logic [15:0] r_entry;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [1:0]  w_retry_nxt;
    logic [2:0]  w_step_nxt;
    logic        w_cmd_en;
    logic [15:0] w_cnt_inc;
    logic [1:0]  w_retry_inc;
    logic        w_can_retry;

    // Assert asynchronously, release two edges later so the FSM never moves
    // in the cycle rst_n goes high.
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_cnt_inc   = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 16'd1;
    assign w_retry_inc = (r_retry == 2'd3) ? r_retry : r_retry + 2'd1;
    assign w_can_retry = (r_retry < c_max_retry);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_step_nxt  = r_step;
        w_cmd_en    = 1'b0;
        case (r_state)
            c_idle, c_done, c_error: begin
                if (start) begin
                    w_state_nxt = c_pwrup;
                    w_step_nxt  = 3'd0;
                    w_retry_nxt = 2'd0;
                    w_cnt_nxt   = 16'd0;
                end
            end
            c_pwrup: begin
                if (r_cnt == c_pwrup_last) begin
                    w_state_nxt = c_issue;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            c_issue: begin
                if (bus_free) begin
                    w_cmd_en    = 1'b1;
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = c_wait_acc;
                end
            end
            c_wait_acc, c_wait_free: begin
                // A bus_free edge wins over a same-cycle timeout.
                if ((r_state == c_wait_acc) && !bus_free) begin
                    w_state_nxt = c_wait_free;
                    w_cnt_nxt   = 16'd0;
                end else if ((r_state == c_wait_free) && bus_free) begin
                    w_cnt_nxt = 16'd0;
                    if (r_step == c_last_step) begin
                        w_state_nxt = c_done;
                    end else begin
                        w_step_nxt  = r_step + 3'd1;
                        w_retry_nxt = 2'd0;
                        w_state_nxt = c_issue;
                    end
                end else if (r_cnt == c_tout_last) begin
                    w_cnt_nxt = 16'd0;
                    if (w_can_retry) begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = c_issue;
                    end else begin
                        w_state_nxt = c_error;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_cnt   <= 16'd0;
            r_retry <= 2'd0;
            r_step  <= 3'd0;
            r_entry <= 16'h1E00;
        end else if (r_rst_sync) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
            r_step  <= w_step_nxt;
            // Looked up on the next step so the fields track step exactly.
            r_entry <= f_entry(w_step_nxt);
        end
    end

    assign cmd_en     = w_cmd_en;
    assign slave_addr = SLAVE_ADDR;
    assign reg_addr   = r_entry[15:8];
    assign reg_data   = r_entry[7:0];
    assign busy       = (r_state != c_idle) && (r_state != c_done) && (r_state != c_error);
    assign done       = (r_state == c_done);
    assign error      = (r_state == c_error);
    assign step       = r_step;

endmodule

`default_nettype wire

// File: doc/audio_codec_init_seq.md
AUDIO_CODEC_INIT_SEQ -- requirements
Module: audio_codec_init_seq

Interface
REQ-001 Parameter SLAVE_ADDR, 8'h35, codec I2C address driven on slave_addr.
REQ-002 Parameter PWRUP_CYCLES, 1000, osc_clk cycles to wait after start before the first command (1..65535).
REQ-003 Parameter TIMEOUT_CYCLES, 50000, maximum osc_clk cycles per handshake phase (1..65535).
REQ-004 Parameter MAX_RETRY, 2, retries per command after a timeout (0..3).
REQ-005 Port osc_clk  in  1  system clock; all logic is on the rising edge.
REQ-006 Port rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port start  in  1  level-sampled request to run the init table.
REQ-008 Port bus_free  in  1  high when the I2C command engine is idle.
REQ-009 Port cmd_en  out  1  one-cycle command strobe to the I2C engine.
REQ-010 Port slave_addr  out  8  constant SLAVE_ADDR.
REQ-011 Port reg_addr  out  8  register field of the current table entry.
REQ-012 Port reg_data  out  8  data field of the current table entry.
REQ-013 Port busy  out  1  high in every state except IDLE, DONE and ERROR.
REQ-014 Port done  out  1  high in DONE.
REQ-015 Port error  out  1  high in ERROR.
REQ-016 Port step  out  3  index of the current table entry.

Function
REQ-017 The internal table SHALL hold 8 entries (reg, data), index 0..7: (1E,00) (0A,FF) (0B,FF) (05,00) (07,02) (08,00) (22,50) (25,C0); this is hex and is also the issue order.
REQ-018 The states SHALL be IDLE, PWRUP, ISSUE, WAIT_ACC, WAIT_FREE, DONE and ERROR.
REQ-019 IDLE, DONE or ERROR with start=1 -> PWRUP; step:=0, retry count:=0, cycle counter:=0.
REQ-020 PWRUP: the counter SHALL increment each cycle; when it reaches PWRUP_CYCLES-1 -> ISSUE.
REQ-021 ISSUE: the block SHALL hold while bus_free=0; on the first cycle with bus_free=1 it SHALL assert cmd_en for exactly that cycle, clear the counter and go -> WAIT_ACC.
REQ-022 WAIT_ACC: bus_free=0 -> WAIT_FREE with the counter cleared; otherwise the counter increments, and when it reaches TIMEOUT_CYCLES-1 the timeout rule (REQ-024) applies.
REQ-023 WAIT_FREE: bus_free=1 -> if step=7 go DONE, else step+1, retry:=0, -> ISSUE; the counter and timeout rule SHALL be as in WAIT_ACC.
REQ-024 Timeout: if retry<MAX_RETRY then retry+1 and -> ISSUE with the same step; else -> ERROR, with step frozen at the failing index.
REQ-025 reg_addr and reg_data SHALL be a registered lookup of step, and SHALL be stable from one cycle before cmd_en until step changes.
REQ-026 cmd_en SHALL never be high for two consecutive cycles, and SHALL never be high outside ISSUE.
REQ-027 start while busy=1 SHALL be ignored, with no restart and no effect on step.
REQ-028 The counter and retry count SHALL saturate and never wrap.
REQ-029 done and error SHALL be mutually exclusive; each SHALL hold until the next accepted start.
REQ-030 bus_free rising and timeout expiry in the same cycle: bus_free takes priority (success).

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, cmd_en=0, busy=0, done=0, error=0, step=0, reg_addr=8'h1E, reg_data=8'h00, and counter=0.
REQ-032 slave_addr SHALL equal SLAVE_ADDR at all times, including during reset.
REQ-033 Reset asserted mid-transfer SHALL abort with no further cmd_en; after release the block SHALL sit in IDLE until start.
REQ-034 Reset release SHALL be synchronized to osc_clk so that no state change occurs in the release cycle.

Verification
REQ-035 Nominal run, PWRUP_CYCLES=4, with an engine model that drops bus_free 2 cycles after cmd_en and raises it 10 cycles later -> 8 cmd_en pulses with (reg,data) matching REQ-017 in order, then done=1, busy=0, step=7.
REQ-036 bus_free held 0 for 20 cycles on entry to ISSUE -> no cmd_en until bus_free=1; then one pulse.
REQ-037 Engine ignores step 3 once, TIMEOUT_CYCLES=16, MAX_RETRY=2 -> step 3 is re-issued after 16 cycles, the sequence completes, done=1.
REQ-038 Engine never accepts step 5, MAX_RETRY=2 -> exactly 3 cmd_en pulses for step 5, then error=1, step=5, busy=0; start then restarts from step 0.
REQ-039 rst_n pulsed low while in WAIT_FREE at step 4 -> all outputs take their REQ-031 values asynchronously, with no cmd_en until a new start.
REQ-040 start pulsed again during busy at step 2 -> the sequence is unaffected, and cmd_en pulses total 8.
